line_fill_responder: RTL
========================

Name: line_fill_responder

Overview:
- Memory-side responder for the cache line-fill interface; sits between the instruction cache's miss port and on-chip backing storage.
- Accepts one line read request at a time.
- Models a fixed access latency and returns one MemBusWidth line with a single-cycle done strobe.
- Includes a load/write port so the boot loader and benches can fill memory contents.

Parameters:
- AddrBusWidth, 32, byte address width of the request bus.
- MemBusWidth, 64, line width in bits; must be a power of two and ≥ 8.
- Depth, 1024, number of lines in backing storage; power of two.
- Latency, 4, cycles from request accept to done; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_addr  in  AddrBusWidth  byte address of the requested line; sampled on accept.
- mem_avail  in  1  request strobe from the cache.
- mem_busy  out  1  responder occupied; requester must not issue while high.
- mem_data  out  MemBusWidth  line data; valid only while mem_done=1, otherwise 0.
- mem_done  out  1  one-cycle completion strobe.
- wr_en  in  1  backing-store write enable.
- wr_addr  in  AddrBusWidth  byte address of the line to write.
- wr_data  in  MemBusWidth  line write data.

Behaviour:
- Derived widths:
  - OffBits = $clog2(MemBusWidth/8).
  - IdxBits = $clog2(Depth).
  - Line index = addr[OffBits+IdxBits-1:OffBits].
  - Offset bits and bits above the index are ignored, so addresses wrap modulo Depth lines.
- Reset (rst=0, asynchronous):
  - mem_busy=0, mem_done=0, mem_data=0, state=IDLE, counter=0, latched index=0.
  - Any pending request is dropped; no done is issued for it.
  - Storage contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: if mem_avail=1 in cycle T, latch the line index and load counter=Latency-1.
    - If Latency=1, go to RESP; otherwise go to WAIT.
    - mem_busy=1 from T+1.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge. On that edge, register mem_data from storage[index] and set mem_done=1.
  - RESP: lasts exactly one cycle (T+Latency). mem_done=1, mem_busy=1. Next state is IDLE; mem_busy=0 and mem_done=0 from T+Latency+1.
- Cycle summary:
  - mem_busy is high from T+1 through T+Latency inclusive.
  - mem_done is high only at T+Latency.
  - The earliest next accept is at T+Latency+1.
- mem_avail rules:
  - mem_avail is ignored in WAIT and RESP. The cache re-asserts mem_avail in the done cycle, and this must not start a new request.
  - mem_avail held high continuously in IDLE yields back-to-back requests, one every Latency+1 cycles.
- Write port:
  - wr_en writes storage[wr index] on the rising edge, in any state.
  - If a write hits the pending line on the same edge that loads mem_data, mem_data returns the old contents (read-before-write).
  - A write to the pending line on an earlier edge is visible in the response.
- mem_data is driven 0 in every cycle where mem_done=0, and is registered, not combinational.
- mem_busy and mem_done are registered outputs with no combinational path from any input.

Test Plan:
- Basic fill (Latency=4): write line 5 = 0x1122334455667788; mem_avail=1 with mem_addr=0x28 at T -> mem_busy=1 at T+1..T+4; mem_done=1 and mem_data=0x1122334455667788 only at T+4; mem_busy=0 at T+5.
- Ignored request: mem_avail pulsed at T+2 with mem_addr=0x40, then held high through T+4 (done cycle) -> exactly one done, for line 5. With mem_avail still high at T+5, a second request is accepted and done occurs at T+9 with line 8 data.
- Latency=1 build: request at T -> mem_done at T+1, mem_busy high only at T+1; back-to-back requests complete every 2 cycles.
- Write collision: request line 3 (old 0xAAAA) at T; wr_en to line 3 with 0xBBBB on the T+4 edge -> done returns 0xAAAA; a re-request returns 0xBBBB.
- Address wrap: Depth=1024, mem_addr=0x2010 -> returns line 2 data (0x2010>>3 = 0x402, mod 1024 = 2); offset bits 0x7 also ignored.
- Reset mid-operation: assert rst=0 at T+2 (asynchronous, between edges) -> mem_busy and mem_done drop immediately; after release, no stray mem_done; a new request completes normally with the earlier-written storage data intact.

Source files
------------

// File: rtl/line_fill_responder.sv
// Memory-side responder for the instruction cache line-fill port: one line read
// at a time, returned after a fixed latency, plus a write port for preloading.
module line_fill_responder #(
    parameter int AddrBusWidth = 32,
    parameter int MemBusWidth  = 64,
    parameter int Depth        = 1024,
    parameter int Latency      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddrBusWidth-1:0] mem_addr,
    input  logic                    mem_avail,
    output logic                    mem_busy,
    output logic [MemBusWidth-1:0]  mem_data,
    output logic                    mem_done,
    input  logic                    wr_en,
    input  logic [AddrBusWidth-1:0] wr_addr,
    input  logic [MemBusWidth-1:0]  wr_data
);

    localparam int OffBits = $clog2(MemBusWidth / 8);
    localparam int IdxBits = $clog2(Depth);
    localparam int CntW    = (Latency > 1) ? $clog2(Latency) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [MemBusWidth-1:0] storage [Depth];

    logic [1:0]         state;
    logic [CntW-1:0]    counter;
    logic [IdxBits-1:0] index;
    logic [IdxBits-1:0] req_index;
    logic [IdxBits-1:0] wr_index;

    // Offset bits and bits above the index are don't-care; addresses wrap.
    assign req_index = mem_addr[OffBits+IdxBits-1:OffBits];
    assign wr_index  = wr_addr[OffBits+IdxBits-1:OffBits];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr, wr_addr};

    // NOTE: storage has no reset so it maps onto plain RAM; contents survive rst.
    // Non-blocking write against the non-blocking read below gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_index] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            counter  <= '0;
            index    <= '0;
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            mem_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_done <= 1'b0;
                    mem_data <= '0;
                    mem_busy <= 1'b0;
                    if (mem_avail) begin
                        index    <= req_index;
                        counter  <= CntW'(Latency - 1);
                        mem_busy <= 1'b1;
                        if (Latency == 1) begin
                            state    <= S_RESP;
                            mem_done <= 1'b1;
                            mem_data <= storage[req_index];
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    counter <= counter - 1'b1;
                    if (counter == CntW'(1)) begin
                        state    <= S_RESP;
                        mem_done <= 1'b1;
                        mem_data <= storage[index];
                    end
                end
                S_RESP: begin
                    // mem_avail is deliberately ignored here; the cache re-asserts it early.
                    state    <= S_IDLE;
                    mem_busy <= 1'b0;
                    mem_done <= 1'b0;
                    mem_data <= '0;
                end
                default: begin
                    state    <= S_IDLE;
                    mem_busy <= 1'b0;
                    mem_done <= 1'b0;
                    mem_data <= '0;
                end
            endcase
        end
    end

endmodule
